// File: rtl/ycbcr444_to_422.sv
// 4:4:4 to 4:2:2 chroma downsampler: averages Cb/Cr over each horizontal pixel
// pair and interleaves them onto one chroma bus, with a fixed 3-clock latency.
module ycbcr444_to_422 #(
    parameter int PIXEL_WIDTH = 8,
    parameter bit CB_FIRST    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIXEL_WIDTH-1:0] y_i,
    input  logic [PIXEL_WIDTH-1:0] cb_i,
    input  logic [PIXEL_WIDTH-1:0] cr_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] y_o,
    output logic [PIXEL_WIDTH-1:0] c_o,
    output logic                   c_sel_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);

    localparam int W = PIXEL_WIDTH;

    logic         cnt;
    logic [W-1:0] a_y, a_cb, a_cr;
    logic         a_de, a_hs, a_vs, a_ph;
    logic [W-1:0] b_y, b_cb, b_cr;
    logic         b_de, b_hs, b_vs, b_ph;
    logic [W-1:0] hold;

    logic [W-1:0] partner_cb, partner_cr;
    logic [W:0]   sum_cb, sum_cr;
    logic [W-1:0] avg_cb, avg_cr, avg1, avg2;
    logic [1:0]   unused_lsbs;

    // Stage A: input register; the phase restarts at 0 at every de run
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 1'b0;
            a_y  <= '0;
            a_cb <= '0;
            a_cr <= '0;
            a_de <= 1'b0;
            a_hs <= 1'b0;
            a_vs <= 1'b0;
            a_ph <= 1'b0;
        end else begin
            a_y  <= y_i;
            a_cb <= cb_i;
            a_cr <= cr_i;
            a_de <= de_i;
            a_hs <= hs_i;
            a_vs <= vs_i;
            if (de_i) begin
                a_ph <= cnt;
                cnt  <= ~cnt;
            end else begin
                a_ph <= 1'b0;
                cnt  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_y  <= '0;
            b_cb <= '0;
            b_cr <= '0;
            b_de <= 1'b0;
            b_hs <= 1'b0;
            b_vs <= 1'b0;
            b_ph <= 1'b0;
        end else begin
            b_y  <= a_y;
            b_cb <= a_cb;
            b_cr <= a_cr;
            b_de <= a_de;
            b_hs <= a_hs;
            b_vs <= a_vs;
            b_ph <= a_ph;
        end
    end

    // An unpaired last pixel averages with itself, which yields its own value
    always_comb begin
        partner_cb = a_de ? a_cb : b_cb;
        partner_cr = a_de ? a_cr : b_cr;
        sum_cb     = {1'b0, b_cb} + {1'b0, partner_cb} + (W+1)'(1);
        sum_cr     = {1'b0, b_cr} + {1'b0, partner_cr} + (W+1)'(1);
        avg_cb     = sum_cb[W:1];
        avg_cr     = sum_cr[W:1];
        unused_lsbs = {sum_cb[0], sum_cr[0]};
        avg1       = CB_FIRST ? avg_cb : avg_cr;
        avg2       = CB_FIRST ? avg_cr : avg_cb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_o     <= '0;
            c_o     <= '0;
            c_sel_o <= 1'b0;
            de_o    <= 1'b0;
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
            hold    <= '0;
        end else begin
            de_o <= b_de;
            hs_o <= b_hs;
            vs_o <= b_vs;
            if (b_de) begin
                y_o <= b_y;
                if (!b_ph) begin
                    c_o     <= avg1;
                    c_sel_o <= 1'b0;
                    hold    <= avg2;
                end else begin
                    c_o     <= hold;
                    c_sel_o <= 1'b1;
                end
            end else begin
                y_o     <= '0;
                c_o     <= '0;
                c_sel_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ycbcr444_to_422.sv
// Directed bench for ycbcr444_to_422: two instances (Cb-first and Cr-first)
// share one stimulus stream and are checked against hand-computed values.
module tb_ycbcr444_to_422;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] y_i, cb_i, cr_i;
    logic       de_i, hs_i, vs_i;

    logic [7:0] y1, c1, y0, c0;
    logic       sel1, de1, hs1, vs1, sel0, de0, hs0, vs0;

    int total_checks = 0;
    int bad_checks   = 0;

    logic       hist_de [0:1023];
    logic       hist_hs [0:1023];
    logic       hist_vs [0:1023];
    logic       hist_ph [0:1023];
    logic [7:0] hist_y  [0:1023];
    int         n_hist;

    always #5 clk = ~clk;

    ycbcr444_to_422 #(.PIXEL_WIDTH(8), .CB_FIRST(1'b1)) dut_cb (
        .clk(clk), .rst(rst), .y_i(y_i), .cb_i(cb_i), .cr_i(cr_i),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .y_o(y1), .c_o(c1), .c_sel_o(sel1), .de_o(de1), .hs_o(hs1), .vs_o(vs1)
    );

    ycbcr444_to_422 #(.PIXEL_WIDTH(8), .CB_FIRST(1'b0)) dut_cr (
        .clk(clk), .rst(rst), .y_i(y_i), .cb_i(cb_i), .cr_i(cr_i),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .y_o(y0), .c_o(c0), .c_sel_o(sel0), .de_o(de0), .hs_o(hs0), .vs_o(vs0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        if (obs !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one input vector and advances past the next rising edge
    task automatic applyStimulus(input logic r, input logic [7:0] y, input logic [7:0] cb,
                                 input logic [7:0] cr, input logic de, input logic hs,
                                 input logic vs);
        rst  = r;
        y_i  = y;
        cb_i = cb;
        cr_i = cr;
        de_i = de;
        hs_i = hs;
        vs_i = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pixel(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        applyStimulus(1'b0, y, cb, cr, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic expectPix(input string tag, input logic [7:0] y, input logic [7:0] cf1,
                             input logic [7:0] cf0, input logic sel, input logic de);
        checkOutput({tag, "_y"},    32'(y1),   32'(y));
        checkOutput({tag, "_c"},    32'(c1),   32'(cf1));
        checkOutput({tag, "_sel"},  32'(sel1), 32'(sel));
        checkOutput({tag, "_de"},   32'(de1),  32'(de));
        checkOutput({tag, "_y0"},   32'(y0),   32'(y));
        checkOutput({tag, "_c0"},   32'(c0),   32'(cf0));
        checkOutput({tag, "_sel0"}, 32'(sel0), 32'(sel));
    endtask

    task automatic expectAllZero(input string tag);
        checkOutput({tag, "_vec"}, {16'h0, y1, c1, sel1, de1, hs1, vs1, 4'h0}, 32'h0);
        checkOutput({tag, "_vec0"}, {16'h0, y0, c0, sel0, de0, hs0, vs0, 4'h0}, 32'h0);
    endtask

    // One cycle of the sync test; outputs are compared with the vector from 2 applies ago
    task automatic syncCycle(input logic de, input logic hs, input logic vs, input logic ph);
        logic [7:0] y;
        y = 8'($urandom_range(1, 255));
        applyStimulus(1'b0, y, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), de, hs, vs);
        hist_de[n_hist] = de;
        hist_hs[n_hist] = hs;
        hist_vs[n_hist] = vs;
        hist_ph[n_hist] = ph;
        hist_y[n_hist]  = y;
        n_hist++;
        if (n_hist >= 3) begin
            checkOutput("sync_de", 32'(de1), 32'(hist_de[n_hist-3]));
            checkOutput("sync_hs", 32'(hs1), 32'(hist_hs[n_hist-3]));
            checkOutput("sync_vs", 32'(vs1), 32'(hist_vs[n_hist-3]));
            if (hist_de[n_hist-3]) begin
                checkOutput("sync_y",   32'(y1),   32'(hist_y[n_hist-3]));
                checkOutput("sync_sel", 32'(sel1), 32'(hist_ph[n_hist-3]));
            end else begin
                checkOutput("blank_y",  32'(y1), 32'h0);
                checkOutput("blank_c",  32'(c1), 32'h0);
                checkOutput("blank_c0", 32'(c0), 32'h0);
            end
        end
    endtask

    initial begin
        // Reset with live-looking inputs must still hold every output at zero
        applyStimulus(1'b1, 8'h5A, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h5A, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h5A, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1);
        expectAllZero("reset");
        idle(); idle(); idle();

        pixel(8'h10, 8'h80, 8'h40);
        pixel(8'h20, 8'h81, 8'h42);
        idle(); expectPix("pair0", 8'h10, 8'h81, 8'h41, 1'b0, 1'b1);
        idle(); expectPix("pair1", 8'h20, 8'h41, 8'h81, 1'b1, 1'b1);
        idle(); expectPix("pair_end", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        pixel(8'h11, 8'hFF, 8'h00);
        pixel(8'h22, 8'hFF, 8'h01);
        idle(); expectPix("ext0", 8'h11, 8'hFF, 8'h01, 1'b0, 1'b1);
        idle(); expectPix("ext1", 8'h22, 8'h01, 8'hFF, 1'b1, 1'b1);
        idle();

        // Odd line of 3, one blank clock, then a 2-pixel line
        pixel(8'h10, 8'h80, 8'h40);
        pixel(8'h20, 8'h81, 8'h42);
        pixel(8'h30, 8'h55, 8'hAA); expectPix("odd0", 8'h10, 8'h81, 8'h41, 1'b0, 1'b1);
        idle();                     expectPix("odd1", 8'h20, 8'h41, 8'h81, 1'b1, 1'b1);
        pixel(8'h40, 8'h10, 8'h20); expectPix("odd2", 8'h30, 8'h55, 8'hAA, 1'b0, 1'b1);
        pixel(8'h50, 8'h30, 8'h40); expectPix("odd_gap", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        idle();                     expectPix("b2b0", 8'h40, 8'h20, 8'h30, 1'b0, 1'b1);
        idle();                     expectPix("b2b1", 8'h50, 8'h30, 8'h20, 1'b1, 1'b1);
        idle();                     expectPix("b2b_end", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        idle();

        // Reset after the third pixel of a 10-pixel line
        applyStimulus(1'b0, 8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h04, 8'h06, 8'h07, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h07, 8'h08, 8'h09, 1'b1, 1'b1, 1'b0);
        expectPix("mid_r1", 8'h01, 8'h04, 8'h05, 1'b0, 1'b1);
        checkOutput("mid_r1_hs", 32'(hs1), 32'h1);
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        expectAllZero("mid_rst");
        pixel(8'h44, 8'h10, 8'h90);
        pixel(8'h55, 8'h13, 8'h95);
        pixel(8'h66, 8'h20, 8'hA0); expectPix("mid_r4", 8'h44, 8'h12, 8'h93, 1'b0, 1'b1);
        pixel(8'h77, 8'h20, 8'hA0); expectPix("mid_r5", 8'h55, 8'h93, 8'h12, 1'b1, 1'b1);
        pixel(8'h88, 8'h30, 8'hB0); expectPix("mid_r6", 8'h66, 8'h20, 8'hA0, 1'b0, 1'b1);
        pixel(8'h99, 8'h32, 8'hB2); expectPix("mid_r7", 8'h77, 8'hA0, 8'h20, 1'b1, 1'b1);
        pixel(8'hAA, 8'h3C, 8'hBC); expectPix("mid_r8", 8'h88, 8'h31, 8'hB1, 1'b0, 1'b1);
        idle();                     expectPix("mid_r9", 8'h99, 8'hB1, 8'h31, 1'b1, 1'b1);
        idle();                     expectPix("mid_r10", 8'hAA, 8'h3C, 8'hBC, 1'b0, 1'b1);
        idle();                     expectPix("mid_end", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Two frames of 8x4 with random blanking and random hs/vs everywhere
        n_hist = 0;
        for (int f = 0; f < 2; f++) begin
            for (int ln = 0; ln < 4; ln++) begin
                for (int b = 0; b < int'($urandom_range(1, 4)); b++)
                    syncCycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                for (int p = 0; p < 8; p++)
                    syncCycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(p % 2));
            end
        end
        for (int b = 0; b < 4; b++)
            syncCycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
